// File: rtl/td4_data_selector_if.sv
// Operand-selector bus: the three candidate operands, the two decoded select
// bits and the selected operand, grouped for the TD4 ALU input path.
interface td4_data_selector_if #(
  parameter int unsigned WIDTH = 4
);
  logic [WIDTH-1:0] IN_A;
  logic [WIDTH-1:0] IN_B;
  logic [WIDTH-1:0] IN_SW;
  logic             SEL_A;
  logic             SEL_B;
  logic [WIDTH-1:0] OUT_Y;

  modport master (
    output IN_A, IN_B, IN_SW, SEL_A, SEL_B,
    input  OUT_Y
  );

  modport slave (
    input  IN_A, IN_B, IN_SW, SEL_A, SEL_B,
    output OUT_Y
  );
endinterface

// File: rtl/td4_data_selector.sv
// TD4 ALU-operand selector: A, B, switch port or zero, optionally registered.
// Define DATA_SELECTOR_SW_SYNC_EN to pass IN_SW through a 2-flop synchroniser.
module td4_data_selector #(
  parameter int unsigned WIDTH   = 4,
  parameter bit          OUT_REG = 1'b1
) (
  input  logic                CLK,
  input  logic                RST,
  td4_data_selector_if.slave  bus
);

  logic [WIDTH-1:0] sw_path;
  logic [WIDTH-1:0] y_d;

`ifdef DATA_SELECTOR_SW_SYNC_EN
  logic [WIDTH-1:0] sw_meta_q;
  logic [WIDTH-1:0] sw_sync_q;

  always_ff @(posedge CLK) begin
    if (RST) begin
      sw_meta_q <= '0;
      sw_sync_q <= '0;
    end else begin
      sw_meta_q <= bus.IN_SW;
      sw_sync_q <= sw_meta_q;
    end
  end

  assign sw_path = sw_sync_q;
`else
  assign sw_path = bus.IN_SW;
`endif

  // Unknown select bits fall through to the default and yield zero.
  always_comb begin
    y_d = '0;
    case ({bus.SEL_B, bus.SEL_A})
      2'b00:   y_d = bus.IN_A;
      2'b01:   y_d = bus.IN_B;
      2'b10:   y_d = sw_path;
      default: y_d = '0;
    endcase
  end

  generate
    if (OUT_REG) begin : g_reg
      logic [WIDTH-1:0] y_q;

      always_ff @(posedge CLK) begin
        if (RST) begin
          y_q <= '0;
        end else begin
          y_q <= y_d;
        end
      end

      assign bus.OUT_Y = y_q;
    end else begin : g_comb
      assign bus.OUT_Y = y_d;
    end
  endgenerate

endmodule

// File: tb/tb_td4_data_selector.sv
// Bench for td4_data_selector: registered and combinational instances driven in
// lockstep, checked against a queue-based reference of the selection rules.
module tb_td4_data_selector;

  localparam int unsigned W = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  td4_data_selector_if #(.WIDTH(W)) bus_r ();
  td4_data_selector_if #(.WIDTH(W)) bus_c ();

  td4_data_selector #(.WIDTH(W), .OUT_REG(1'b1)) dut_r (
    .CLK (clk),
    .RST (rst),
    .bus (bus_r.slave)
  );

  td4_data_selector #(.WIDTH(W), .OUT_REG(1'b0)) dut_c (
    .CLK (clk),
    .RST (rst),
    .bus (bus_c.slave)
  );

  int tests  = 0;
  int failed = 0;

  logic [W-1:0] expq[$];
  bit           stim_done = 1'b0;
  bit           mon_done  = 1'b0;

  // Switch values and reset flags seen at each rising edge, oldest first.
  logic [W-1:0] hist_sw[$];
  bit           hist_rst[$];

  logic [W-1:0] prev_exp;
  bit           have_prev = 1'b0;

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %b, expected %b at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [W-1:0] ref_sel(input logic sb, input logic sa,
                                           input logic [W-1:0] a, input logic [W-1:0] b,
                                           input logic [W-1:0] sw);
    logic [W-1:0] choice [4];
    logic [1:0]   s;
    if ($isunknown({sb, sa})) return '0;
    choice[0] = a;
    choice[1] = b;
    choice[2] = sw;
    choice[3] = '0;
    s = {sb, sa};
    return choice[s];
  endfunction

  // Switch value the mux sees at the coming edge.
  function automatic logic [W-1:0] sw_seen(input logic [W-1:0] sw_now);
`ifdef DATA_SELECTOR_SW_SYNC_EN
    int unsigned n = hist_sw.size();
    if (hist_rst[n-1] || hist_rst[n-2]) return '0;
    return hist_sw[n-2];
`else
    return sw_now;
`endif
  endfunction

  task automatic step(input bit r, input logic sb, input logic sa,
                      input logic [W-1:0] a, input logic [W-1:0] b, input logic [W-1:0] sw,
                      input string tag);
    logic [W-1:0] sel_val;
    logic [W-1:0] exp_r;
    @(negedge clk);
    rst = r;
    bus_r.SEL_B = sb; bus_r.SEL_A = sa; bus_r.IN_A = a; bus_r.IN_B = b; bus_r.IN_SW = sw;
    bus_c.SEL_B = sb; bus_c.SEL_A = sa; bus_c.IN_A = a; bus_c.IN_B = b; bus_c.IN_SW = sw;
    sel_val = ref_sel(sb, sa, a, b, sw_seen(sw));
    exp_r   = r ? '0 : sel_val;
    #1;
    if (have_prev) check({tag, "_hold"}, bus_r.OUT_Y, prev_exp);
    check({tag, "_comb"}, bus_c.OUT_Y, sel_val);
    expq.push_back(exp_r);
    prev_exp  = exp_r;
    have_prev = 1'b1;
    hist_sw.push_back(sw);
    hist_rst.push_back(r);
  endtask

  // Monitor: the registered output is presented once per edge.
  initial begin : monitor
    logic [W-1:0] e;
    for (int cyc = 0; cyc < 5000; cyc++) begin
      @(posedge clk);
      #1;
      if (expq.size() > 0) begin
        e = expq.pop_front();
        check("reg", bus_r.OUT_Y, e);
      end else if (stim_done) begin
        break;
      end
    end
    mon_done = 1'b1;
  end

  initial begin : stimulus
    logic [W-1:0] a, b, sw;
    logic         sa, sb;
    bit           r;
    logic         xv;
    hist_sw.push_back('0);  hist_rst.push_back(1'b1);
    hist_sw.push_back('0);  hist_rst.push_back(1'b1);

    step(1'b1, 1'b0, 1'b0, 4'b0001, 4'b0010, 4'b0100, "rst0");
    step(1'b1, 1'b0, 1'b0, 4'b0001, 4'b0010, 4'b0100, "rst1");
    step(1'b0, 1'b0, 1'b0, 4'b0001, 4'b0010, 4'b0100, "selA");
    step(1'b0, 1'b0, 1'b1, 4'b0001, 4'b0010, 4'b0100, "selB");
    step(1'b0, 1'b1, 1'b0, 4'b0001, 4'b0010, 4'b0100, "selSW");
    step(1'b0, 1'b1, 1'b1, 4'b0001, 4'b0010, 4'b0100, "selZ");
    step(1'b0, 1'b0, 1'b0, 4'b1111, 4'b0010, 4'b0100, "A_F");
    step(1'b1, 1'b0, 1'b0, 4'b1111, 4'b0010, 4'b0100, "midrst");
    step(1'b0, 1'b0, 1'b0, 4'b1111, 4'b0010, 4'b0100, "postrst");
    step(1'b0, 1'b1, 1'b1, 4'b1111, 4'b1111, 4'b1111, "zero_all1");
    xv = 1'bx;
    step(1'b0, xv, 1'b0, 4'b1010, 4'b0101, 4'b0110, "selX");
    step(1'b0, 1'b1, 1'b0, 4'b1010, 4'b0101, 4'b0000, "sw0");
    step(1'b0, 1'b1, 1'b0, 4'b1010, 4'b0101, 4'b1010, "swA");
    step(1'b0, 1'b1, 1'b0, 4'b1010, 4'b0101, 4'b1010, "swA1");
    step(1'b0, 1'b1, 1'b0, 4'b1010, 4'b0101, 4'b1010, "swA2");

    for (int unsigned i = 0; i < 400; i++) begin
      r  = ($urandom_range(0, 19) == 0);
      sb = 1'($urandom());
      sa = 1'($urandom());
      a  = W'($urandom());
      b  = W'($urandom());
      sw = W'($urandom());
      step(r, sb, sa, a, b, sw, "rand");
    end

    stim_done = 1'b1;
    for (int cyc = 0; cyc < 100 && !mon_done; cyc++) @(posedge clk);
    #2;
    tests++;
    if (!mon_done || expq.size() != 0) begin
      failed++;
      $display("FAIL drain: monitor_done=%0d, %0d expected outputs left, required 1 and 0",
               mon_done, expq.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
